// File: rtl/repeated_sub_divider.sv
// -----------------------------------------------------------------------------
// repeated_sub_divider
//
// Unsigned divider using repeated subtraction. The dividend and then the
// divisor arrive on the shared data_in bus on the two cycles after start is
// accepted. The block then subtracts the divisor from the running remainder
// once per cycle, incrementing the quotient, until the remainder is smaller
// than the divisor. A zero divisor finishes immediately with div_by_zero set,
// quotient all-ones and the dividend left as the remainder.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division (accepted only in IDLE or DONE)
//   data_in      operand bus: dividend, then divisor on the next cycle
//   quotient     registered quotient
//   remainder    registered remainder
//   busy         high while loading operands or subtracting
//   done         high while the result is held in DONE
//   div_by_zero  high in DONE when the captured divisor was zero
// -----------------------------------------------------------------------------
module repeated_sub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        SUB    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic             dbz_q,       dbz_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            quotient_q  <= '0;
            remainder_q <= '0;
            divisor_q   <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divisor_q   <= divisor_d;
            dbz_q       <= dbz_d;
        end
    end

    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case statement leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divisor_d   = divisor_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                remainder_d = data_in;
                state_d     = LOAD_B;
            end
            LOAD_B: begin
                divisor_d  = data_in;
                quotient_d = '0;
                dbz_d      = 1'b0;
                state_d    = SUB;
            end
            SUB: begin
                if (divisor_q == '0) begin
                    // Remainder keeps the dividend captured in LOAD_A.
                    dbz_d      = 1'b1;
                    quotient_d = '1;
                    state_d    = DONE;
                end else if (remainder_q >= divisor_q) begin
                    remainder_d = remainder_q - divisor_q;
                    quotient_d  = quotient_q + WIDTH'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) state_d = LOAD_A;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == SUB);
    assign done        = (state_q == DONE);

endmodule

// File: doc/repeated_sub_divider.md
REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE or DONE.
REQ-005 data_in  input  WIDTH  shared operand bus: dividend, then divisor, on consecutive cycles.
REQ-006 quotient  output  WIDTH  registered quotient.
REQ-007 remainder  output  WIDTH  registered remainder.
REQ-008 busy  output  1  high in LOAD_A, LOAD_B, SUB.
REQ-009 done  output  1  high only in state DONE.
REQ-010 div_by_zero  output  1  high in DONE when the captured divisor was 0.

Function
REQ-011 FSM states SHALL be exactly IDLE, LOAD_A, LOAD_B, SUB and DONE; all outputs registered or decoded from state.
REQ-012 IDLE: start=1 at edge N -> LOAD_A; otherwise stay.
REQ-013 LOAD_A: edge N+1 captures data_in as dividend into remainder register -> LOAD_B.
REQ-014 LOAD_B: edge N+2 captures data_in as divisor, clears quotient to 0, clears div_by_zero -> SUB.
REQ-015 SUB with divisor==0: next edge sets div_by_zero=1, quotient=all-ones, remainder unchanged (equal to dividend) -> DONE.
REQ-016 SUB with remainder>=divisor (unsigned): next edge remainder<=remainder-divisor, quotient<=quotient+1, stay in SUB.
REQ-017 SUB with remainder<divisor: next edge -> DONE, registers unchanged.
REQ-018 Latency: for nonzero divisor, done rises after edge N+3+Q (Q = final quotient); divide-by-zero: after edge N+3.
REQ-019 Quotient never exceeds 2^WIDTH-1 (divisor>=1); no overflow handling required.
REQ-020 DONE: hold quotient, remainder, div_by_zero, done=1 until start=1; start in DONE -> LOAD_A (same sequencing as REQ-012, edge taken as N).
REQ-021 start while busy SHALL be ignored; data_in is ignored outside LOAD_A/LOAD_B.
REQ-022 done and busy SHALL never be high simultaneously.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, regardless of current state.
REQ-024 Reset deasserted mid-operation SHALL leave the block in IDLE with the aborted operation discarded; a new start is required.

Verification
REQ-025 start at edge N, data_in=100 then 7 -> done after edge N+17, quotient=14, remainder=2, div_by_zero=0.
REQ-026 5 / 9 -> done after edge N+3, quotient=0, remainder=5.
REQ-027 0 / 0 and 42 / 0 -> done after edge N+3, div_by_zero=1, quotient=16'hFFFF, remainder=0 and 42 respectively.
REQ-028 65535 / 1 -> done after edge N+65538, quotient=65535, remainder=0; start pulses during SUB have no effect.
REQ-029 rst_n pulsed low mid-SUB of 1000/3 -> outputs zero asynchronously, state IDLE, no done until new start.
REQ-030 Back-to-back: from DONE of 100/7, start with 9/4 -> busy next cycle, done after edge N+5, quotient=2, remainder=1.
